// File: rtl/debug_dump_tx.sv
// -----------------------------------------------------------------------------
// debug_dump_tx
//   Transmit side of the MIPS debug link. On request it serializes a snapshot
//   of the PC, the register file and data memory over a UART line (8N1):
//     0xA5 | PC | REG[0..NUM_REGISTERS-1] | MEM[0..MEM_SIZE-1] | 0x5A
//   Words go least-significant byte first; bytes go LSB first.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_rst        asynchronous reset, active low
//   i_start      dump request, sampled only while idle
//   i_pc         PC value, captured on the start-accept edge
//   o_reg_addr   register-file read address
//   i_reg_data   register read data (combinational from o_reg_addr)
//   o_mem_addr   data-memory read address (word index)
//   i_mem_data   memory read data (combinational from o_mem_addr)
//   o_uart_tx    serial line, idle high
//   o_busy       high from start accept until frame end (stalls the CPU)
//   o_done       one-cycle pulse at frame end
//   o_dbg_state  current word-level FSM state
//
// Start/busy/done handshake: i_start is a level request sampled only in IDLE;
// the accepting edge raises o_busy for the next cycle. Requests seen while
// busy or in DONE are dropped, not queued. o_done and the fall of o_busy
// coincide in the single DONE cycle, which is always followed by at least one
// IDLE cycle.
// -----------------------------------------------------------------------------
module debug_dump_tx #(
    parameter int SIZE          = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int MEM_SIZE      = 64,
    parameter int ADDR_WIDTH    = $clog2(MEM_SIZE),
    parameter int CLKS_PER_BIT  = 2604
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [SIZE-1:0]       i_pc,
    output logic [4:0]            o_reg_addr,
    input  logic [SIZE-1:0]       i_reg_data,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [SIZE-1:0]       i_mem_data,
    output logic                  o_uart_tx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2:0]            o_dbg_state
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int BYTES = SIZE / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CW-1:0]         CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]         BYTE_LAST = BW'(BYTES - 1);
    localparam logic [4:0]            REG_LAST  = 5'(NUM_REGISTERS - 1);
    localparam logic [ADDR_WIDTH-1:0] MEM_LAST  = ADDR_WIDTH'(MEM_SIZE - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_PC   = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_WORD = 3'd4;
    localparam logic [2:0] S_TRL  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]            state_q,     state_d;
    logic [CW-1:0]         clk_cnt_q,   clk_cnt_d;
    logic [3:0]            bit_cnt_q,   bit_cnt_d;    // 0 start, 1..8 data, 9 stop
    logic [BW-1:0]         byte_idx_q,  byte_idx_d;
    logic [SIZE-1:0]       word_q,      word_d;       // current byte sits in [7:0]
    logic [SIZE-1:0]       pc_q,        pc_d;
    logic [4:0]            reg_addr_q,  reg_addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic                  mem_phase_q, mem_phase_d;
    logic                  tx_q,        tx_d;

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        pc_d        = pc_q;
        reg_addr_d  = reg_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_phase_d = mem_phase_q;
        tx_d        = tx_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (i_start) begin
                    pc_d       = i_pc;
                    word_d     = SIZE'(8'hA5);
                    state_d    = S_HDR;
                    clk_cnt_d  = '0;
                    bit_cnt_d  = 4'd0;
                    byte_idx_d = '0;
                    tx_d       = 1'b0;
                end
            end

            S_HDR, S_PC, S_WORD, S_TRL: begin
                if (clk_cnt_q != CLK_LAST) begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end else begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q != 4'd9) begin
                        // tx_d is the level of the bit being entered, so it
                        // leaves the flop aligned with the bit boundary.
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = (bit_cnt_q == 4'd8) ? 1'b1 : word_q[bit_cnt_q[2:0]];
                    end else begin
                        bit_cnt_d = 4'd0;
                        case (state_q)
                            S_HDR: begin
                                state_d    = S_PC;
                                word_d     = pc_q;
                                byte_idx_d = '0;
                                tx_d       = 1'b0;
                            end
                            S_TRL: begin
                                state_d = S_DONE;
                                tx_d    = 1'b1;
                            end
                            default: begin
                                if (byte_idx_q != BYTE_LAST) begin
                                    byte_idx_d = byte_idx_q + BW'(1);
                                    word_d     = word_q >> 8;
                                    tx_d       = 1'b0;
                                end else begin
                                    // Word finished: advance the read address so
                                    // it is stable for the whole LOAD cycle.
                                    byte_idx_d = '0;
                                    tx_d       = 1'b1;
                                    state_d    = S_LOAD;
                                    if (state_q == S_WORD) begin
                                        if (!mem_phase_q) begin
                                            if (reg_addr_q == REG_LAST) begin
                                                reg_addr_d  = 5'd0;
                                                mem_phase_d = 1'b1;
                                            end else begin
                                                reg_addr_d = reg_addr_q + 5'd1;
                                            end
                                        end else if (mem_addr_q == MEM_LAST) begin
                                            mem_addr_d  = '0;
                                            mem_phase_d = 1'b0;
                                            state_d     = S_TRL;
                                            word_d      = SIZE'(8'h5A);
                                            tx_d        = 1'b0;
                                        end else begin
                                            mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                                        end
                                    end
                                end
                            end
                        endcase
                    end
                end
            end

            S_LOAD: begin
                word_d     = mem_phase_q ? i_mem_data : i_reg_data;
                state_d    = S_WORD;
                clk_cnt_d  = '0;
                bit_cnt_d  = 4'd0;
                byte_idx_d = '0;
                tx_d       = 1'b0;
            end

            S_DONE: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= 4'd0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            pc_q        <= '0;
            reg_addr_q  <= 5'd0;
            mem_addr_q  <= '0;
            mem_phase_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            pc_q        <= pc_d;
            reg_addr_q  <= reg_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_phase_q <= mem_phase_d;
            tx_q        <= tx_d;
        end
    end

    assign o_reg_addr  = reg_addr_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_uart_tx   = tx_q;
    assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done      = (state_q == S_DONE);
    assign o_dbg_state = state_q;

endmodule
